// File: rtl/binary_to_bcd_decoder_if.sv
// Start/result bundle for the binary-to-BCD decoder.
// The master drives start/binary; the slave answers with ready/done/bcd.
interface binary_to_bcd_decoder_if #(
  parameter int WIDTH  = 8,
  parameter int DIGITS = 3
);
  logic                  start;
  logic [WIDTH-1:0]      binary;
  logic                  ready;
  logic                  done;
  logic [4*DIGITS-1:0]   bcd;

  modport master (output start, output binary, input ready, input done, input bcd);
  modport slave  (input start, input binary, output ready, output done, output bcd);
endinterface

// File: rtl/binary_to_bcd_decoder.sv
// Sequential double-dabble converter: one input bit per clock.
// Produces packed BCD digits with a one-cycle done pulse.
module binary_to_bcd_decoder #(
  parameter int WIDTH  = 8,
  parameter int DIGITS = 3
) (
  input  logic                     clk,
  input  logic                     rst,
  binary_to_bcd_decoder_if.slave   bus
);

  localparam int CW = $clog2(WIDTH + 1);
  localparam longint unsigned DEC_RANGE = 64'd10 ** DIGITS;
  localparam longint unsigned BIN_MAX   = (64'd1 << WIDTH) - 64'd1;

  generate
    if (WIDTH < 4 || WIDTH > 16) begin : g_bad_width
      $error("binary_to_bcd_decoder: WIDTH must be in 4..16");
    end
    if (DEC_RANGE <= BIN_MAX) begin : g_bad_digits
      $error("binary_to_bcd_decoder: DIGITS too small to hold 2**WIDTH-1");
    end
  endgenerate

  typedef enum logic [1:0] {
    S_IDLE  = 2'd0,
    S_SHIFT = 2'd1,
    S_DONE  = 2'd2
  } state_t;

  state_t                r_state;
  state_t                w_state_next;
  logic [WIDTH-1:0]      r_shift;
  logic [4*DIGITS-1:0]   r_scratch;
  logic [CW-1:0]         r_count;
  logic [4*DIGITS-1:0]   r_bcd;

  logic [4*DIGITS-1:0]   w_adj;
  logic [4*DIGITS-1:0]   w_scratch_next;
  logic [WIDTH-1:0]      w_shift_next;

  // Per-digit add-3 correction; digits never carry into each other.
  generate
    for (genvar gi = 0; gi < DIGITS; gi++) begin : g_adj
      assign w_adj[4*gi +: 4] = (r_scratch[4*gi +: 4] >= 4'd5) ?
                                (r_scratch[4*gi +: 4] + 4'd3) :
                                r_scratch[4*gi +: 4];
    end
  endgenerate

  assign w_scratch_next = {w_adj[4*DIGITS-2:0], r_shift[WIDTH-1]};
  assign w_shift_next   = {r_shift[WIDTH-2:0], 1'b0};

  always_ff @(posedge clk) begin
    if (rst) begin
      r_state   <= S_IDLE;
      r_shift   <= '0;
      r_scratch <= '0;
      r_count   <= '0;
      r_bcd     <= '0;
    end else begin
      r_state <= w_state_next;
      case (r_state)
        S_IDLE: begin
          if (bus.start) begin
            r_shift   <= bus.binary;
            r_scratch <= '0;
            r_count   <= CW'(WIDTH);
          end
        end
        S_SHIFT: begin
          r_shift   <= w_shift_next;
          r_scratch <= w_scratch_next;
          r_count   <= r_count - 1'b1;
          // The last shift lands directly in the result register.
          if (r_count == CW'(1)) begin
            r_bcd <= w_scratch_next;
          end
        end
        default: begin
        end
      endcase
    end
  end

  always_comb begin
    w_state_next = r_state;
    case (r_state)
      S_IDLE:  if (bus.start) w_state_next = S_SHIFT;
      S_SHIFT: if (r_count == CW'(1)) w_state_next = S_DONE;
      S_DONE:  w_state_next = S_IDLE;
      default: w_state_next = S_IDLE;
    endcase
  end

  // Outputs decode only the state register, so nothing reaches them from start/binary.
  always_comb begin
    bus.ready = (r_state == S_IDLE);
    bus.done  = (r_state == S_DONE);
    bus.bcd   = r_bcd;
  end

endmodule

// File: tb/tb_binary_to_bcd_decoder.sv
// Scoreboard bench for binary_to_bcd_decoder: expected BCD is queued at accept
// and compared when done pulses; a second 4-bit instance covers alternate sizing.
module tb_binary_to_bcd_decoder;

  logic clk = 1'b0;
  logic rst = 1'b1;
  always #5 clk = ~clk;

  binary_to_bcd_decoder_if #(.WIDTH(8), .DIGITS(3)) bus ();
  binary_to_bcd_decoder_if #(.WIDTH(4), .DIGITS(2)) bus4 ();

  binary_to_bcd_decoder #(.WIDTH(8), .DIGITS(3)) dut (
    .clk (clk),
    .rst (rst),
    .bus (bus)
  );

  binary_to_bcd_decoder #(.WIDTH(4), .DIGITS(2)) dut4 (
    .clk (clk),
    .rst (rst),
    .bus (bus4)
  );

  int n_checks = 0;
  int n_fail   = 0;
  int n_start  = 0;
  int n_done   = 0;
  logic [31:0] sb[$];

  task automatic check_val(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s got=%0h exp=%0h", tag, got, exp);
    end
  endtask

  function automatic logic [31:0] bcd_ref(input int v, input int nd);
    logic [31:0] r;
    int x;
    r = '0;
    x = v;
    for (int k = 0; k < nd; k++) begin
      r = r | (32'(x % 10) << (4 * k));
      x = x / 10;
    end
    return r;
  endfunction

  always @(negedge clk) begin
    if (bus.done === 1'b1) begin
      logic [31:0] e;
      n_done++;
      check_val("ready_low_in_done", {31'd0, bus.ready}, 32'd0);
      check_val("sb_has_entry", {31'd0, (sb.size() != 0)}, 32'd1);
      if (sb.size() != 0) begin
        e = sb.pop_front();
        check_val("bcd", {20'd0, bus.bcd}, e);
        $display("txn bcd=%03h exp=%03h", bus.bcd, e[11:0]);
      end
    end
  end

  task automatic wait_ready();
    int n;
    n = 0;
    while (bus.ready !== 1'b1 && n < 40) begin
      @(negedge clk);
      n++;
    end
    check_val("ready_before_start", {31'd0, bus.ready}, 32'd1);
  endtask

  task automatic wait_done(input int lat_start, output int lat);
    lat = lat_start;
    while (bus.done !== 1'b1 && lat < 40) begin
      @(negedge clk);
      lat++;
    end
  endtask

  task automatic do_conv(input int v);
    int lat;
    wait_ready();
    bus.start  = 1'b1;
    bus.binary = 8'(v);
    sb.push_back(bcd_ref(v, 3));
    n_start++;
    @(negedge clk);
    bus.start  = 1'b0;
    bus.binary = 8'($urandom);
    wait_done(1, lat);
    check_val("latency", 32'(lat), 32'd9);
  endtask

  initial begin
    #2000000;
    $display("FAIL watchdog got=timeout exp=finish");
    $fatal(1, "watchdog");
  end

  initial begin
    int lat;
    bus.start   = 1'b0;
    bus.binary  = '0;
    bus4.start  = 1'b0;
    bus4.binary = '0;

    // Reset then idle
    rst = 1'b1;
    repeat (2) @(negedge clk);
    check_val("rst_ready", {31'd0, bus.ready}, 32'd1);
    check_val("rst_done", {31'd0, bus.done}, 32'd0);
    check_val("rst_bcd", {20'd0, bus.bcd}, 32'h000);
    check_val("rst4_ready", {31'd0, bus4.ready}, 32'd1);
    rst = 1'b0;
    for (int i = 0; i < 20; i++) begin
      @(negedge clk);
      check_val("idle_ready", {31'd0, bus.ready}, 32'd1);
      check_val("idle_done", {31'd0, bus.done}, 32'd0);
      check_val("idle_bcd", {20'd0, bus.bcd}, 32'h000);
    end

    // Corner values
    do_conv(0);
    do_conv(255);
    do_conv(99);

    // Exhaustive sweep at minimum spacing
    for (int v = 0; v < 256; v++) begin
      do_conv(v);
    end

    // Start ignored while busy
    wait_ready();
    bus.start  = 1'b1;
    bus.binary = 8'd128;
    sb.push_back(bcd_ref(128, 3));
    n_start++;
    @(negedge clk);
    bus.start = 1'b0;
    @(negedge clk);
    @(negedge clk);
    bus.start  = 1'b1;
    bus.binary = 8'd77;
    @(negedge clk);
    bus.start = 1'b0;
    wait_done(4, lat);
    check_val("busy_latency", 32'(lat), 32'd9);
    bus.start  = 1'b1;
    bus.binary = 8'd77;
    @(negedge clk);
    check_val("busy_ready_after_done", {31'd0, bus.ready}, 32'd1);
    check_val("busy_done_low", {31'd0, bus.done}, 32'd0);
    bus.start = 1'b0;
    repeat (15) @(negedge clk);
    check_val("busy_no_second_conv", {31'd0, bus.ready}, 32'd1);
    check_val("busy_bcd_held", {20'd0, bus.bcd}, 32'h128);

    // Reset mid-conversion
    wait_ready();
    bus.start  = 1'b1;
    bus.binary = 8'd200;
    @(negedge clk);
    bus.start = 1'b0;
    repeat (4) @(negedge clk);
    rst = 1'b1;
    @(negedge clk);
    check_val("midrst_ready", {31'd0, bus.ready}, 32'd1);
    check_val("midrst_done", {31'd0, bus.done}, 32'd0);
    check_val("midrst_bcd", {20'd0, bus.bcd}, 32'h000);
    rst = 1'b0;
    repeat (12) @(negedge clk);
    check_val("midrst_idle_bcd", {20'd0, bus.bcd}, 32'h000);
    do_conv(42);
    @(negedge clk);
    check_val("after_rst_bcd", {20'd0, bus.bcd}, 32'h042);

    // Alternate sizing: WIDTH=4, DIGITS=2
    lat = 0;
    while (bus4.ready !== 1'b1 && lat < 40) begin
      @(negedge clk);
      lat++;
    end
    check_val("w4_ready", {31'd0, bus4.ready}, 32'd1);
    bus4.start  = 1'b1;
    bus4.binary = 4'd15;
    @(negedge clk);
    bus4.start = 1'b0;
    lat = 1;
    while (bus4.done !== 1'b1 && lat < 40) begin
      @(negedge clk);
      lat++;
    end
    check_val("w4_latency", 32'(lat), 32'd5);
    check_val("w4_bcd", {24'd0, bus4.bcd}, bcd_ref(15, 2));
    $display("txn w4 bcd=%02h", bus4.bcd);

    repeat (3) @(negedge clk);
    check_val("done_count", 32'(n_done), 32'(n_start));
    check_val("sb_empty", 32'(sb.size()), 32'd0);

    $display("TB_RESULT checks=%0d failures=%0d", n_checks, n_fail);
    $finish;
  end

endmodule

// File: doc/binary_to_bcd_decoder.md
# binary_to_bcd_decoder

Sequential binary-to-BCD decoder: the reverse direction of the team's decimal-to-binary encoder. Accepts an unsigned binary word on a start strobe and converts it with a shift-and-add-3 (double-dabble) engine, one input bit per clock. Presents packed BCD digits with a one-cycle done pulse. Sits between arithmetic/counter datapaths and digit display or readout logic.

## Interface
- WIDTH, 8, bit width of the binary input; legal range 4..16.
- DIGITS, 3, number of BCD output digits.
  - Must satisfy 10^DIGITS > 2^WIDTH − 1.
  - An elaboration-time check fails the build otherwise.
- clk  input  1  single clock; all state changes on rising edge.
- rst  input  1  synchronous, active-high reset.
- start  input  1  request a conversion; sampled only when ready=1.
- binary  input  WIDTH  unsigned value to convert; sampled on the same edge as an accepted start.
- ready  output  1  high only in IDLE; a conversion can be accepted.
- done  output  1  one-cycle pulse; bcd holds a new result.
- bcd  output  4*DIGITS  packed BCD result; digit k occupies bits [4k+3:4k], digit 0 is least significant.

## Operation
- States:
  - IDLE: ready=1. Start=1 on an edge latches binary into a shift register, clears the digit scratch register, loads bit counter = WIDTH, and moves to SHIFT.
  - SHIFT: each cycle does two steps. First, every scratch digit ≥ 5 gets +3 (4-bit add, no carry between digits). Second, {scratch, shift register} shifts left by 1, moving the shift register MSB into scratch bit 0, and the counter decrements. When the counter reaches 1 on an edge, the final shift is performed, bcd is loaded with the resulting scratch value, and the state moves to DONE.
  - DONE: done=1 for exactly this cycle; ready=0. The next edge returns to IDLE unconditionally.
- Start is ignored in SHIFT and DONE: no queuing, no abort, no effect on the result.
- The binary input is don't-care except on the accepting edge; changes during SHIFT do not affect the result.
- bcd is updated only on the edge entering DONE. It holds its value otherwise, including through IDLE, until the next completed conversion.
- Every scratch digit value after an add-3 step stays ≤ 15. Each final digit is 0..9; no value outside 0..9 ever appears on bcd.
- Leading zero digits are output as 4'b0000; there is no blanking.
- Reset, whether asserted in IDLE or mid-conversion, forces the following on the next edge:
  - state=IDLE, ready=1, done=0, bcd=0
  - shift register, scratch and counter cleared
  - an aborted conversion never produces done
  - a start sampled in the same cycle as rst=1 is discarded.

## Timing
- Start is accepted on edge E0; SHIFT occupies the cycles after edges E0..E(WIDTH−1).
- Edge E_WIDTH enters DONE: done=1 and the new bcd are visible in the cycle after E_WIDTH. Latency is WIDTH+1 cycles from the accepting edge to done visible.
- Edge E(WIDTH+1) returns to IDLE: ready=1. Minimum start-to-start spacing is WIDTH+2 cycles; a new start can be accepted on E(WIDTH+2).
- ready and done are registered outputs with no combinational path from start or binary.
- ready and done are never both high in the same cycle.

## Test plan
- Reset then idle (WIDTH=8, DIGITS=3): assert rst 2 cycles, release -> ready=1, done=0, bcd=12'h000. Hold start=0 for 20 cycles -> outputs unchanged.
- Corner values: start with binary=0, then 255, then 99, each started on the first ready -> done appears 9 cycles after each accepting edge, with bcd=12'h000, 12'h255, 12'h099 respectively.
- Exhaustive sweep 0..255, back-to-back at minimum spacing of 10 cycles -> every bcd matches the decimal reference model. Exactly one done per start.
- Start ignored while busy: accept binary=128, then pulse start with binary=77 in SHIFT cycle 3 and again in the DONE cycle -> a single done with bcd=12'h128. ready returns 1 cycle after done and no second conversion runs.
- Reset mid-conversion: accept binary=200, assert rst in SHIFT cycle 5 -> no done, bcd=12'h000, ready=1 the cycle after reset. A following conversion of binary=42 yields bcd=12'h042.
- Alternate parameters: WIDTH=4, DIGITS=2, binary=15 -> done 5 cycles after accept, bcd=8'h15. Separately, WIDTH=8 with DIGITS=2 -> elaboration fails.
